// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Brief    : Shared defaults, widths and FSM encoding for the FIR sample
//             sequencer and its multiply-accumulate datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int FIR_DATA_W = 16;                 // sample / coeff / result width
  localparam int FIR_TAPS   = 4;                  // window depth
  localparam int FIR_FRAC_W = 15;                 // Q1.15 coefficients
  localparam int FIR_ACC_W  = 2*FIR_DATA_W + 2;   // headroom for TAPS signed sums

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    MAC   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fir_mac.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac
//  Brief    : Unsigned multiply feeding a signed add/subtract accumulator.
//             The sequencer chooses add or subtract per tap and clears the
//             accumulator before each new sample.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2*DATA_W + 2
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    acc_clr,
  input  logic                    acc_en,
  input  logic                    sel_sub,
  input  logic [DATA_W-1:0]       sample,
  input  logic [DATA_W-1:0]       coeff,
  output logic signed [ACC_W-1:0] acc
);

  logic [2*DATA_W-1:0]     product;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  // Product is always non-negative; zero-extend before the signed add/subtract
  always_comb begin
    product  = {{DATA_W{1'b0}}, sample} * {{DATA_W{1'b0}}, coeff};
    prod_ext = $signed({{(ACC_W-2*DATA_W){1'b0}}, product});
    acc_d    = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = sel_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule
`default_nettype wire

// File: rtl/fir_sample_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fir_sample_ctrl
//  Brief    : Sample sequencer for the FIR: captures a sample or coefficient
//             on handshake, shifts the sample window, runs one tap per cycle
//             through fir_mac with alternating sign, saturates the result and
//             pulses cnt_up / clear towards the sample counter.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_sample_ctrl
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int TAPS   = FIR_TAPS,
  parameter int FRAC_W = FIR_FRAC_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              data_ready,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              load_coeff,
  input  logic [DATA_W-1:0] coeff_in,
  output logic              modwait,
  output logic [DATA_W-1:0] fir_out,
  output logic              err,
  output logic              cnt_up,
  output logic              clear
);

  localparam int ACC_W = 2*DATA_W + 2;
  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       hold_q, hold_d;
  logic [DATA_W-1:0]       win_q   [TAPS];
  logic [DATA_W-1:0]       win_d   [TAPS];
  logic [DATA_W-1:0]       coeff_q [TAPS];
  logic [DATA_W-1:0]       coeff_d [TAPS];
  logic [IDX_W-1:0]        tap_idx_q, tap_idx_d;
  logic [IDX_W-1:0]        coeff_idx_q, coeff_idx_d;
  logic [DATA_W-1:0]       fir_out_q, fir_out_d;
  logic                    err_q, err_d;
  logic                    cnt_up_q, cnt_up_d;
  logic                    clear_q, clear_d;
  logic                    modwait_q, modwait_d;
  logic                    acc_clr, acc_en;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] res;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a coefficient write takes priority over a new sample
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_coeff)      state_d = LOAD;
        else if (data_ready) state_d = SHIFT;
      end
      LOAD:    state_d = IDLE;
      SHIFT:   state_d = MAC;
      MAC:     if (tap_idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: registered handshake pulses plus datapath strobes
  always_comb begin
    modwait_d = (state_q != IDLE);
    cnt_up_d  = (state_q == DONE);
    clear_d   = (state_q == LOAD) && (coeff_idx_q == LAST_IDX);
    acc_clr   = (state_q == SHIFT);
    acc_en    = (state_q == MAC);
  end

  fir_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .n_rst   (n_rst),
    .acc_clr (acc_clr),
    .acc_en  (acc_en),
    .sel_sub (tap_idx_q[0]),
    .sample  (win_q[tap_idx_q]),
    .coeff   (coeff_q[tap_idx_q]),
    .acc     (acc)
  );

  // Datapath next values: input capture, window shift, coeff file, saturation
  always_comb begin
    hold_d      = hold_q;
    win_d       = win_q;
    coeff_d     = coeff_q;
    tap_idx_d   = tap_idx_q;
    coeff_idx_d = coeff_idx_q;
    fir_out_d   = fir_out_q;
    err_d       = err_q;
    res         = acc >>> FRAC_W;
    case (state_q)
      IDLE: begin
        if (load_coeff)      hold_d = coeff_in;
        else if (data_ready) hold_d = sample_data;
      end
      LOAD: begin
        coeff_d[coeff_idx_q] = hold_q;
        coeff_idx_d = (coeff_idx_q == LAST_IDX) ? '0 : coeff_idx_q + 1'b1;
      end
      SHIFT: begin
        for (int i = TAPS-1; i > 0; i--) begin
          win_d[i] = win_q[i-1];
        end
        win_d[0]  = hold_q;
        tap_idx_d = '0;
      end
      MAC: begin
        tap_idx_d = tap_idx_q + 1'b1;
      end
      DONE: begin
        if (res[ACC_W-1]) begin
          fir_out_d = '0;
          err_d     = 1'b1;
        end else if (|res[ACC_W-2:DATA_W]) begin
          fir_out_d = '1;
          err_d     = 1'b1;
        end else begin
          fir_out_d = res[DATA_W-1:0];
          err_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hold_q      <= '0;
      win_q       <= '{default: '0};
      coeff_q     <= '{default: '0};
      tap_idx_q   <= '0;
      coeff_idx_q <= '0;
      fir_out_q   <= '0;
      err_q       <= 1'b0;
      cnt_up_q    <= 1'b0;
      clear_q     <= 1'b0;
      modwait_q   <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      win_q       <= win_d;
      coeff_q     <= coeff_d;
      tap_idx_q   <= tap_idx_d;
      coeff_idx_q <= coeff_idx_d;
      fir_out_q   <= fir_out_d;
      err_q       <= err_d;
      cnt_up_q    <= cnt_up_d;
      clear_q     <= clear_d;
      modwait_q   <= modwait_d;
    end
  end

  assign modwait = modwait_q;
  assign fir_out = fir_out_q;
  assign err     = err_q;
  assign cnt_up  = cnt_up_q;
  assign clear   = clear_q;

endmodule
`default_nettype wire
